gpio_seq_checker: RTL and testbench

Receive-side checker for the GPIO speed test. It samples the 10-bit bus driven by the wrapping 0..MAX_VAL test counter at the far end of the GPIO link, locks onto the sequence, and flags every sample that breaks the +1 / wrap-to-0 progression. It also keeps saturating error and wrap counters that software reads to qualify link integrity at each tested toggle rate. It sits directly behind the GPIO input pins, in the same clock domain as the transmitting counter.

---
 rtl/gpio_speed_pkg.sv | 30 +++
 rtl/sat_counter.sv | 38 +++
 rtl/gpio_seq_checker.sv | 181 ++++++++++++++++++
 tb/tb_gpio_seq_checker.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_speed_pkg.sv
// ============================================================================
// Module : gpio_speed_pkg
// Brief  : Constants, state encoding and next-value helper shared between the
//          GPIO speed-test transmit counter and the receive-side checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_speed_pkg;

    // Test bus width and last counter value before wrapping back to zero
    localparam int c_GPIO_WIDTH   = 10;
    localparam int c_GPIO_MAX_VAL = 999;

    // Sequence checker states: searching, acquiring lock, locked and checking
    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Successor of a counter value: wraps to zero after max_val
    function automatic logic [31:0] next_val(input logic [31:0] value,
                                             input logic [31:0] max_val);
        return (value == max_val) ? 32'd0 : value + 32'd1;
    endfunction

endpackage : gpio_speed_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear; clear has priority
//          over a same-cycle increment and the count never wraps.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_MAX_COUNT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count up on inc, hold at all-ones, zero on clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX_COUNT)) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/gpio_seq_checker.sv
// ============================================================================
// Module : gpio_seq_checker
// Brief  : Receive-side checker for the GPIO speed test. Locks onto the
//          wrapping 0..MAX_VAL counter sequence, flags every sample that
//          breaks the progression and keeps saturating error/wrap counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_seq_checker
    import gpio_speed_pkg::*;
#(
    parameter int WIDTH   = c_GPIO_WIDTH,
    parameter int MAX_VAL = c_GPIO_MAX_VAL,
    parameter int LOCK_N  = 4,
    parameter int LOSS_N  = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] last_bad
);

    localparam int               c_MCW       = $clog2(LOCK_N + 1);
    localparam int               c_BRW       = $clog2(LOSS_N + 1);
    localparam logic [WIDTH-1:0] c_MAX       = WIDTH'(MAX_VAL);
    localparam logic [c_MCW-1:0] c_LOCK_LAST = c_MCW'(LOCK_N - 1);
    localparam logic [c_BRW-1:0] c_LOSS_LAST = c_BRW'(LOSS_N - 1);

    logic [WIDTH-1:0] r_data_q;
    state_t           r_state;
    logic [WIDTH-1:0] r_exp;
    logic [c_MCW-1:0] r_match_cnt;
    logic [c_BRW-1:0] r_bad_run;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_prev_ok;
    logic             r_prev_max;
    logic [WIDTH-1:0] r_last_bad;

    logic             w_in_range;
    logic             w_match;
    logic [WIDTH-1:0] w_nxt_data;
    logic [WIDTH-1:0] w_nxt_exp;
    logic             w_err_inc;
    logic             w_wrap_inc;

    assign w_in_range = (r_data_q <= c_MAX);
    assign w_match    = (r_data_q == r_exp);
    assign w_nxt_data = WIDTH'(next_val(32'(r_data_q), 32'(MAX_VAL)));
    assign w_nxt_exp  = WIDTH'(next_val(32'(r_exp), 32'(MAX_VAL)));

    // An error is only counted once the sequence is locked
    assign w_err_inc  = (r_state == ST_CHECK) && !w_match;

    // A wrap counts only when both the MAX_VAL sample and this zero were on-sequence
    assign w_wrap_inc = (r_state == ST_CHECK) && w_match && (r_data_q == '0)
                        && r_prev_max && r_prev_ok;

    // Input stage: all sequence decisions are made on the registered sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= data;
        end
    end

    // Sequence FSM: hunt for an in-range value, qualify a run, then check
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_exp       <= '0;
            r_match_cnt <= '0;
            r_bad_run   <= '0;
            r_locked    <= 1'b0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_in_range) begin
                        r_state     <= ST_LOCK;
                        r_exp       <= w_nxt_data;
                        r_match_cnt <= c_MCW'(1);
                    end
                end
                ST_LOCK: begin
                    if (!w_in_range) begin
                        r_state <= ST_HUNT;
                    end else if (w_match) begin
                        r_exp       <= w_nxt_data;
                        r_match_cnt <= r_match_cnt + c_MCW'(1);
                        if (r_match_cnt == c_LOCK_LAST) begin
                            r_state   <= ST_CHECK;
                            r_locked  <= 1'b1;
                            r_bad_run <= '0;
                        end
                    end else begin
                        // Restart the qualifying run from this new value
                        r_match_cnt <= c_MCW'(1);
                        r_exp       <= w_nxt_data;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_bad_run <= '0;
                        r_exp     <= w_nxt_data;
                    end else begin
                        // Resync on a plausible value, otherwise free-run the expectation
                        r_exp     <= w_in_range ? w_nxt_data : w_nxt_exp;
                        r_bad_run <= r_bad_run + c_BRW'(1);
                        if (r_bad_run == c_LOSS_LAST) begin
                            r_state  <= ST_HUNT;
                            r_locked <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Error strobe and history of the previous sample for wrap qualification
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_pulse <= 1'b0;
            r_prev_ok   <= 1'b0;
            r_prev_max  <= 1'b0;
        end else begin
            r_err_pulse <= w_err_inc;
            r_prev_ok   <= (r_state != ST_HUNT) && w_match;
            r_prev_max  <= (r_data_q == c_MAX);
        end
    end

    // Capture the latest offending sample; clear takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_bad <= '0;
        end else if (clear) begin
            r_last_bad <= '0;
        end else if (w_err_inc) begin
            r_last_bad <= r_data_q;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (clear),
        .i_inc   (w_err_inc),
        .o_count (err_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_wrap_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (clear),
        .i_inc   (w_wrap_inc),
        .o_count (wrap_count)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign last_bad  = r_last_bad;

endmodule : gpio_seq_checker

`default_nettype wire

// File: tb/tb_gpio_seq_checker.sv
// ============================================================================
// Module : tb_gpio_seq_checker
// Brief  : Self-checking bench for gpio_seq_checker: a full-width instance and
//          a narrow-counter instance share stimulus and are compared each
//          cycle against a behavioural sequence model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gpio_seq_checker;

    localparam int MAXV     = 999;
    localparam int LOCKN    = 4;
    localparam int LOSSN    = 8;
    localparam int CW_BIG   = 16;
    localparam int CW_SMALL = 4;

    localparam int M_SEARCH = 0;
    localparam int M_ACQ    = 1;
    localparam int M_TRACK  = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [9:0]  data  = '0;

    logic        b_locked, b_pulse;
    logic [15:0] b_err, b_wrap;
    logic [9:0]  b_last;
    logic        s_locked, s_pulse;
    logic [3:0]  s_err, s_wrap;
    logic [9:0]  s_last;

    always #5 clk = ~clk;

    gpio_seq_checker dut_b (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .clear      (clear),
        .locked     (b_locked),
        .err_pulse  (b_pulse),
        .err_count  (b_err),
        .wrap_count (b_wrap),
        .last_bad   (b_last)
    );

    gpio_seq_checker #(.CNT_W(CW_SMALL)) dut_s (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .clear      (clear),
        .locked     (s_locked),
        .err_pulse  (s_pulse),
        .err_count  (s_err),
        .wrap_count (s_wrap),
        .last_bad   (s_last)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int sv = 0;

    // Behavioural model state
    int md_q, mode, m_exp, m_run, m_badrun, m_prev_v;
    bit m_prev_ok, m_pulse;
    int err_raw, wrap_raw, m_last;

    function automatic int nxt(input int v);
        return (v == MAXV) ? 0 : v + 1;
    endfunction

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endfunction

    task automatic model_reset();
        md_q = 0; mode = M_SEARCH; m_exp = 0; m_run = 0; m_badrun = 0;
        m_prev_v = 0; m_prev_ok = 0; m_pulse = 0;
        err_raw = 0; wrap_raw = 0; m_last = 0;
    endtask

    // One sample through the sequence rules
    task automatic model_step(input bit clr);
        int v;
        bit inr, hit, e, w;
        v   = md_q;
        inr = (v <= MAXV);
        hit = (mode != M_SEARCH) && (v == m_exp);
        e = 0; w = 0;
        if (mode == M_SEARCH) begin
            if (inr) begin mode = M_ACQ; m_exp = nxt(v); m_run = 1; end
        end else if (mode == M_ACQ) begin
            if (!inr) mode = M_SEARCH;
            else begin
                m_run = hit ? m_run + 1 : 1;
                m_exp = nxt(v);
                if (m_run == LOCKN) begin mode = M_TRACK; m_badrun = 0; end
            end
        end else begin
            if (hit) begin
                m_badrun = 0;
                if (v == 0 && m_prev_v == MAXV && m_prev_ok) w = 1;
                m_exp = nxt(v);
            end else begin
                e = 1;
                m_badrun++;
                m_exp = inr ? nxt(v) : nxt(m_exp);
                if (m_badrun == LOSSN) mode = M_SEARCH;
            end
        end
        m_prev_ok = hit;
        m_prev_v  = v;
        m_pulse   = e;
        if (clr) begin
            err_raw = 0; wrap_raw = 0; m_last = 0;
        end else begin
            err_raw  += int'(e);
            wrap_raw += int'(w);
            if (e) m_last = v;
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("b_locked", b_locked, (mode == M_TRACK));
            chk("b_pulse",  b_pulse,  m_pulse);
            chk("b_err",    b_err,    sat(err_raw, CW_BIG));
            chk("b_wrap",   b_wrap,   sat(wrap_raw, CW_BIG));
            chk("b_last",   b_last,   m_last);
            chk("s_locked", s_locked, (mode == M_TRACK));
            chk("s_pulse",  s_pulse,  m_pulse);
            chk("s_err",    s_err,    sat(err_raw, CW_SMALL));
            chk("s_wrap",   s_wrap,   sat(wrap_raw, CW_SMALL));
            chk("s_last",   s_last,   m_last);
        end
    end

    task automatic cyc(input int d, input bit c);
        data  = d[9:0];
        clear = c;
        @(posedge clk);
        #1;
        if (reset) begin
            model_step(c);
            md_q = d;
        end
        @(negedge clk);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(sv, 1'b0);
            sv = nxt(sv);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset  = 1'b0;
        clear  = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        // Reset values
        chk("rst_locked", b_locked, 0);
        chk("rst_pulse",  b_pulse,  0);
        chk("rst_err",    b_err,    0);
        chk("rst_wrap",   b_wrap,   0);
        chk("rst_last",   b_last,   0);
        release_reset();

        // Clean stream from reset release
        sv = 0;
        stream(4);
        chk("lit_lock_c4", b_locked, 0);
        stream(1);
        chk("lit_lock_c5", b_locked, 1);
        stream(2000);
        chk("lit_wrap2", b_wrap, 2);
        chk("lit_err0",  b_err,  0);

        // Single glitch 123 replacing 500
        cyc(sv, 1'b1); sv = nxt(sv);
        while (sv != 500) stream(1);
        cyc(123, 1'b0); sv = nxt(sv);
        stream(1);
        chk("lit_glitch_err1",  b_err,   1);
        chk("lit_glitch_last1", b_last,  123);
        chk("lit_glitch_pulse", b_pulse, 1);
        stream(1);
        chk("lit_glitch_err2",  b_err,   2);
        chk("lit_glitch_last2", b_last,  501);
        stream(6);
        chk("lit_glitch_err2b", b_err,    2);
        chk("lit_glitch_lock",  b_locked, 1);

        // Out-of-range burst drops lock after the 8th error
        cyc(sv, 1'b1); sv = nxt(sv);
        repeat (8) cyc(1023, 1'b0);
        chk("lit_oor_lock7", b_locked, 1);
        chk("lit_oor_err7",  b_err,    7);
        cyc(1023, 1'b0);
        chk("lit_oor_lock8", b_locked, 0);
        chk("lit_oor_err8",  b_err,    8);
        repeat (4) cyc(1023, 1'b0);
        chk("lit_oor_hunt",  b_err,    8);

        // Mid-sequence start: wrap during acquisition is not counted
        do_reset();
        sv = 997;
        stream(5);
        chk("lit_997_lock", b_locked, 1);
        stream(5);
        chk("lit_997_wrap0", b_wrap, 0);
        stream(1000);
        chk("lit_997_wrap1", b_wrap, 1);

        // Short out-of-range bursts: stay locked, narrow counter saturates
        cyc(sv, 1'b1); sv = nxt(sv);
        repeat (3) begin
            repeat (7) begin cyc(1023, 1'b0); sv = nxt(sv); end
            stream(20);
        end
        chk("lit_sat_big",   b_err,    21);
        chk("lit_sat_small", s_err,    15);
        chk("lit_sat_lock",  b_locked, 1);
        cyc(1023, 1'b0); sv = nxt(sv);
        cyc(sv, 1'b1);   sv = nxt(sv);
        chk("lit_clr_err",   b_err,   0);
        chk("lit_clr_pulse", b_pulse, 1);
        stream(10);

        // Randomised stream: glitches, out-of-range values, jumps and clears
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit c;
            r = $urandom_range(99);
            c = ($urandom_range(49) == 0);
            if (r < 85)      cyc(sv, c);
            else if (r < 93) cyc($urandom_range(1023), c);
            else if (r < 96) cyc(1000 + $urandom_range(23), c);
            else begin sv = $urandom_range(MAXV); cyc(sv, c); end
            sv = nxt(sv);
        end

        // Asynchronous reset in the middle of a locked cycle
        stream(10);
        cyc(5, 1'b0); sv = nxt(sv);
        stream(10);
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("lit_arst_locked", b_locked, 0);
        chk("lit_arst_pulse",  b_pulse,  0);
        chk("lit_arst_err",    b_err,    0);
        chk("lit_arst_wrap",   b_wrap,   0);
        chk("lit_arst_last",   b_last,   0);
        repeat (2) @(negedge clk);
        release_reset();
        sv = 500;
        stream(4);
        chk("lit_relock_c4", b_locked, 0);
        stream(1);
        chk("lit_relock_c5", b_locked, 1);
        stream(5);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gpio_seq_checker

`default_nettype wire
